// File: rtl/conv_ofmap_collector_pkg.sv
// -----------------------------------------------------------------------------
// cnn_defs
//   Shared definitions for the convolution output path: default data widths,
//   the output feature-map geometry, the collector state encoding and the
//   row/column counter width helper.
// -----------------------------------------------------------------------------
package cnn_defs;

   localparam int CONV_OFMAP_SIZE = 4;   // rows = cols of the assembled map
   localparam int DATA_WIDTH      = 16;  // unsigned activation width
   localparam int ACC_WIDTH       = 32;  // signed accumulator width
   localparam int FRAC_BITS       = 8;   // fixed-point fraction bits dropped

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } collector_state_t;

   // Width of a row/column index for an n x n map (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int CNT_WIDTH = cnt_width(CONV_OFMAP_SIZE);

endpackage

// File: rtl/conv_ofmap_collector_relu_quant.sv
// -----------------------------------------------------------------------------
// relu_quant
//   Combinational rescale of one convolution accumulator: arithmetic right
//   shift by FRAC_BITS, ReLU (negative -> 0) and unsigned saturation to
//   DATA_WIDTH bits.
// Ports
//   i_acc  in   ACC_WIDTH   signed accumulator value
//   o_q    out  DATA_WIDTH  quantised unsigned activation
// -----------------------------------------------------------------------------
module relu_quant #(
   parameter int DATA_WIDTH = cnn_defs::DATA_WIDTH,
   parameter int ACC_WIDTH  = cnn_defs::ACC_WIDTH,
   parameter int FRAC_BITS  = cnn_defs::FRAC_BITS
) (
   input  logic signed [ACC_WIDTH-1:0]  i_acc,
   output logic        [DATA_WIDTH-1:0] o_q
);

   logic signed [ACC_WIDTH-1:0] w_shift;
   logic                        w_neg;
   logic                        w_ovf;

   always_comb begin
      w_shift = i_acc >>> FRAC_BITS;
      w_neg   = w_shift[ACC_WIDTH-1];
      // Any set bit above the output width on a non-negative value means the
      // value exceeds the largest representable activation.
      w_ovf   = |w_shift[ACC_WIDTH-1:DATA_WIDTH];
   end

   always_comb begin
      o_q = w_shift[DATA_WIDTH-1:0];
      if (w_neg) begin
         o_q = '0;
      end else if (w_ovf) begin
         o_q = '1;
      end
   end

endmodule

// File: rtl/conv_ofmap_collector.sv
// -----------------------------------------------------------------------------
// conv_ofmap_collector
//   Collects the convolution engine's raster-ordered accumulator stream,
//   quantises each result (shift / ReLU / saturate) and assembles an
//   OFMAP_SIZE x OFMAP_SIZE map. When the map is complete it raises pool_en
//   and holds the map frozen until the pooling stage answers with done_pool.
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous reset, active low
//   in_valid   in   1        accumulator result valid
//   in_ready   out  1        collector can accept a result (FILL only)
//   in_data    in   ACC_W    signed accumulator result
//   in_last    in   1        final pixel of a frame
//   ofmap      out  map      assembled map, ofmap[row][col]
//   pool_en    out  1        map complete, pooling may run (HOLD)
//   done_pool  in   1        pooling stage finished (registered upstream)
//   frame_err  out  1        one-cycle pulse on frame-length mismatch
//   busy       out  1        low only in FILL at position [0][0]
// -----------------------------------------------------------------------------
module conv_ofmap_collector #(
   parameter int DATA_WIDTH = cnn_defs::DATA_WIDTH,
   parameter int ACC_WIDTH  = cnn_defs::ACC_WIDTH,
   parameter int OFMAP_SIZE = cnn_defs::CONV_OFMAP_SIZE,
   parameter int FRAC_BITS  = cnn_defs::FRAC_BITS
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   input  logic signed [ACC_WIDTH-1:0]                          in_data,
   input  logic                                                 in_last,
   output logic [OFMAP_SIZE-1:0][OFMAP_SIZE-1:0][DATA_WIDTH-1:0] ofmap,
   output logic                                                 pool_en,
   input  logic                                                 done_pool,
   output logic                                                 frame_err,
   output logic                                                 busy
);

   import cnn_defs::*;

   localparam int               CNT_W    = cnt_width(OFMAP_SIZE);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OFMAP_SIZE - 1);

   collector_state_t r_state;
   collector_state_t w_state_nxt;

   logic [CNT_W-1:0] r_row;
   logic [CNT_W-1:0] r_col;
   logic [CNT_W-1:0] w_row_nxt;
   logic [CNT_W-1:0] w_col_nxt;

   logic [OFMAP_SIZE-1:0][OFMAP_SIZE-1:0][DATA_WIDTH-1:0] r_ofmap;

   logic                  r_frame_err;
   logic                  w_frame_err_nxt;
   logic                  w_wr;
   logic                  w_final;
   logic [DATA_WIDTH-1:0] w_q;

   relu_quant #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_relu_quant (
      .i_acc (in_data),
      .o_q   (w_q)
   );

   always_comb begin
      w_final = (r_row == LAST_IDX) && (r_col == LAST_IDX);
   end

   // Next-state, counter and handshake logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_frame_err_nxt = 1'b0;
      w_wr            = 1'b0;
      in_ready        = 1'b0;
      pool_en         = 1'b0;

      unique case (r_state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_wr = 1'b1;
               if (w_final) begin
                  // Map complete: accepted even without in_last, which is
                  // only flagged. Counters rewind so RELEASE->FILL is clean.
                  w_state_nxt     = HOLD;
                  w_row_nxt       = '0;
                  w_col_nxt       = '0;
                  w_frame_err_nxt = ~in_last;
               end else if (in_last) begin
                  // Premature end of frame: drop the partial map and restart.
                  // Stale elements are overwritten by the next frame.
                  w_row_nxt       = '0;
                  w_col_nxt       = '0;
                  w_frame_err_nxt = 1'b1;
               end else if (r_col == LAST_IDX) begin
                  w_col_nxt = '0;
                  w_row_nxt = r_row + 1'b1;
               end else begin
                  w_col_nxt = r_col + 1'b1;
               end
            end
         end

         HOLD: begin
            pool_en = 1'b1;
            if (done_pool) begin
               w_state_nxt = RELEASE;
            end
         end

         RELEASE: begin
            // done_pool is registered by the pool stage, so wait for it to
            // fall before accepting the next frame.
            if (!done_pool) begin
               w_state_nxt = FILL;
            end
         end

         default: begin
            w_state_nxt = FILL;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= FILL;
         r_row       <= '0;
         r_col       <= '0;
         r_frame_err <= 1'b0;
         r_ofmap     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_frame_err <= w_frame_err_nxt;
         if (w_wr) begin
            r_ofmap[r_row][r_col] <= w_q;
         end
      end
   end

   always_comb begin
      ofmap     = r_ofmap;
      frame_err = r_frame_err;
      busy      = !((r_state == FILL) && (r_row == '0) && (r_col == '0));
   end

endmodule

// File: tb/tb_conv_ofmap_collector.sv
module tb_conv_ofmap_collector;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int N  = 4;
   localparam int FB = 8;

   logic                           clk = 1'b0;
   logic                           reset;
   logic                           in_valid;
   logic                           in_ready;
   logic signed [AW-1:0]           in_data;
   logic                           in_last;
   logic [N-1:0][N-1:0][DW-1:0]    ofmap;
   logic                           pool_en;
   logic                           done_pool;
   logic                           frame_err;
   logic                           busy;

   typedef struct {
      int          r;
      int          c;
      logic [DW-1:0] q;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] exp_map [N][N];
   int            n_tests  = 0;
   int            n_fail   = 0;
   int            beat_idx = 0;

   conv_ofmap_collector #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .OFMAP_SIZE (N),
      .FRAC_BITS  (FB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .ofmap     (ofmap),
      .pool_en   (pool_en),
      .done_pool (done_pool),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference quantiser written with integer division rather than shifts.
   function automatic logic [DW-1:0] model_q(input logic signed [AW-1:0] d);
      longint v;
      longint s;
      v = longint'(d);
      if (v < 0) return '0;
      s = v / 256;
      if (s > 65535) return '1;
      return s[DW-1:0];
   endfunction

   task automatic send_beat(input logic [AW-1:0] d, input logic last);
      exp_t e;
      check_eq($sformatf("ready_b%0d", beat_idx), in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      e.r = beat_idx / N;
      e.c = beat_idx % N;
      e.q = model_q(d);
      sb.push_back(e);
      beat_idx = (beat_idx + 1) % (N * N);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic discard();
      sb.delete();
      beat_idx = 0;
   endtask

   task automatic drain_map(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq($sformatf("%s[%0d][%0d]", tag, e.r, e.c), ofmap[e.r][e.c], e.q);
         exp_map[e.r][e.c] = e.q;
         n++;
      end
      check_eq({tag, "_count"}, n, N * N);
      beat_idx = 0;
   endtask

   task automatic check_frozen(input string tag);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            check_eq($sformatf("%s[%0d][%0d]", tag, r, c), ofmap[r][c], exp_map[r][c]);
   endtask

   task automatic release_pool(input string tag);
      done_pool = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_rel_pool_en"}, pool_en, 0);
      check_eq({tag, "_rel_ready"}, in_ready, 0);
      done_pool = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_fill_ready"}, in_ready, 1);
      check_eq({tag, "_fill_busy"}, busy, 0);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      done_pool = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check_eq("rst_ready", in_ready, 1);
      check_eq("rst_pool_en", pool_en, 0);
      check_eq("rst_frame_err", frame_err, 0);
      check_eq("rst_busy", busy, 0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_map[r][c] = '0;
      check_frozen("rst_map");
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: full frame k<<8
      for (int k = 0; k < N * N; k++) send_beat(AW'(k) << 8, k == N * N - 1);
      check_eq("t1_pool_en", pool_en, 1);
      check_eq("t1_ready", in_ready, 0);
      check_eq("t1_frame_err", frame_err, 0);
      check_eq("t1_busy", busy, 1);
      drain_map("t1");
      check_eq("t1_r3c2", ofmap[3][2], 14);

      // 3: handshake, done_pool held for extra cycles
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("t3_pool_hold", pool_en, 1);
      end
      done_pool = 1'b1;
      @(posedge clk); #1;
      check_eq("t3_pool_drop", pool_en, 0);
      check_eq("t3_ready_rel", in_ready, 0);
      repeat (2) begin
         @(posedge clk); #1;
         check_eq("t3_ready_wait", in_ready, 0);
         check_eq("t3_pool_wait", pool_en, 0);
      end
      done_pool = 1'b0;
      @(posedge clk); #1;
      check_eq("t3_ready_back", in_ready, 1);
      check_eq("t3_busy_idle", busy, 0);
      check_frozen("t3_frozen");

      // 2: quantisation corners plus random accumulators
      send_beat(32'hFFFF_FF00, 1'b0);
      send_beat(32'h00FF_FF80, 1'b0);
      send_beat(32'h0001_23FF, 1'b0);
      for (int k = 3; k < N * N; k++) begin
         if (k % 2 == 0) send_beat($urandom(), k == N * N - 1);
         else            send_beat($urandom_range(0, 32'h00FF_FFFF), k == N * N - 1);
      end
      check_eq("t2_pool_en", pool_en, 1);
      drain_map("t2");
      check_eq("t2_q_neg", ofmap[0][0], 16'h0000);
      check_eq("t2_q_sat", ofmap[0][1], 16'hFFFF);
      check_eq("t2_q_mid", ofmap[0][2], 16'h0123);
      release_pool("t2");

      // 4: early in_last on beat 5; done_pool during FILL ignored
      done_pool = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) done_pool = 1'b0;
         send_beat(32'h0000_0700 + AW'(k), k == 5);
      end
      check_eq("t4_err_pulse", frame_err, 1);
      check_eq("t4_busy_rewind", busy, 0);
      check_eq("t4_pool_en", pool_en, 0);
      check_eq("t4_ready", in_ready, 1);
      discard();
      @(posedge clk); #1;
      check_eq("t4_err_clear", frame_err, 0);
      for (int k = 0; k < N * N; k++) send_beat(32'h0000_A000 + AW'(k) * 32'h1234, k == N * N - 1);
      check_eq("t4_pool_en2", pool_en, 1);
      check_eq("t4_err_none", frame_err, 0);
      drain_map("t4");
      release_pool("t4");

      // 5: missing in_last, then in_valid held during HOLD
      for (int k = 0; k < N * N; k++) send_beat(AW'(k) * 32'h300 + 32'h80, 1'b0);
      check_eq("t5_err_pulse", frame_err, 1);
      check_eq("t5_pool_en", pool_en, 1);
      in_valid = 1'b1;
      in_data  = 32'h0012_3400;
      in_last  = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check_eq("t5_ready_hold", in_ready, 0);
         check_eq("t5_pool_hold", pool_en, 1);
         check_eq("t5_err_once", frame_err, 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain_map("t5");
      release_pool("t5");

      // 6: async reset at beat 9, then reset during HOLD
      for (int k = 0; k < 9; k++) send_beat(AW'(k) * 32'h100 + 32'h5500, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h0000_9900;
      reset    = 1'b0;
      #2;
      check_eq("t6_ready", in_ready, 1);
      check_eq("t6_pool_en", pool_en, 0);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_frame_err", frame_err, 0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_map[r][c] = '0;
      check_frozen("t6_zero");
      discard();
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      for (int k = 0; k < N * N; k++) send_beat(AW'(N * N - k) << 9, k == N * N - 1);
      check_eq("t6_pool_en2", pool_en, 1);
      drain_map("t6");
      reset = 1'b0;
      #1;
      check_eq("t6_hold_rst_pool", pool_en, 0);
      check_eq("t6_hold_rst_ready", in_ready, 1);
      @(posedge clk); #1;
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
